fpu_mul_round_dp: RTL and testbench
===================================

// Module: fpu_mul_round_dp
// PURPOSE
//  Second half of the double-precision multiply path; consumes the raw 106-bit
//  mantissa product, biased exponent sum and sign from the multiplier array.
//  Normalises, rounds (RNE or RTZ), and detects overflow and underflow.
//  Packs an IEEE-754 binary64 result plus exception flags.
//  Two-stage pipeline with valid/ready handshake on both sides; full throughput.
// PARAMETERS
//  WIDTH     64   result width; only 64 is supported
//  EXP_W     13   signed width of incoming exponent sum (eA+eB-1023)
// PORTS
//  clk        in   1    clock, all state on rising edge
//  reset      in   1    asynchronous, active-high reset
//  in_valid   in   1    upstream operand valid
//  in_ready   out  1    block can accept this cycle
//  in_sign    in   1    sign of product (signA ^ signB)
//  in_exp     in   13   two's-complement eA+eB-1023
//  in_prod    in   106  unsigned product of {1,mantA}*{1,mantB}
//  in_class   in   2    0 normal, 1 zero, 2 inf, 3 NaN (precomputed upstream)
//  in_invalid in   1    upstream invalid op (inf*0, sNaN); passed to flag
//  rm         in   1    rounding mode, sampled with in_valid: 0 RNE, 1 RTZ
//  out_valid  out  1    result valid
//  out_ready  in   1    downstream accepts result
//  result     out  64   packed binary64 {sign, exp[10:0], frac[51:0]}
//  flags      out  4    {invalid, overflow, underflow, inexact}
// BEHAVIOUR
//  Reset: s1_valid=0, s2_valid(out_valid)=0, result=0, flags=0; in-flight data dropped.
//  Handshake: transfer when valid&ready; s2 loads when !s2_valid | out_ready.
//   s1 loads when !s1_valid | s2 loads; in_ready = that s1 load condition (comb.).
//   Latency 2 cycles in_valid->out_valid with out_ready held high.
//   out_valid held and result/flags stable while out_ready=0; order preserved, no loss/dup.
//  Stage 1 (normalise):
//   prod[105]=1: frac=prod[104:53], G=prod[52], S=|prod[51:0], e=in_exp+1.
//   prod[105]=0: frac=prod[103:52], G=prod[51], S=|prod[50:0], e=in_exp.
//   Register sign, frac, G, S, e (13b signed), class, invalid, rm.
//  Stage 2 (round/pack), class normal only:
//   inc = RNE ? G&(S|frac[0]) : 0; inexact = G|S.
//   frac+inc carries out: frac=0, e=e+1.
//   e>=2047: overflow=1, inexact=1; RNE -> {sign,7FF,0}; RTZ -> {sign,7FE,all ones}.
//   e<=0: flush to {sign,0,0}; underflow=1, inexact=1; no subnormal output.
//   Otherwise {sign,e[10:0],frac}.
//  Specials bypass rounding; overflow/underflow/inexact=0:
//   zero -> {sign,0,0}; inf -> {sign,7FF,0};
//   NaN -> canonical 64'h7FF8_0000_0000_0000.
//  invalid flag = registered in_invalid for every class.
//  Out-of-range e is tested on the 13-bit signed value before truncation to 11 bits.
// TESTING
//  1.5*1.5: prod=9<<102, in_exp=1023, RNE -> result 64'h4002_0000_0000_0000, flags 0, 2 cycles.
//  Tie-to-even: prod[105:104]=01, frac lsb=1, G=1, S=0, in_exp=1023 -> 64'h3FF0_0000_0000_0002, inexact.
//  Frac carry: prod[103:52] all ones, G=1, in_exp=1023 -> 64'h4000_0000_0000_0000, inexact.
//  Overflow: in_exp=2046, prod[105]=1 -> RNE 64'h7FF0_0000_0000_0000 / RTZ 64'h7FEF_FFFF_FFFF_FFFF, flags 4'b0101.
//  Underflow: in_exp=-5, sign=1 -> 64'h8000_0000_0000_0000, flags 4'b0011; class=3 -> 64'h7FF8..., flags 0.
//  Backpressure/reset: out_ready=0 for 6 cycles, 3 back-to-back inputs -> 2 held, in_ready=0, third accepted after release, in order; reset with both stages full -> out_valid=0 immediately.

Source files
------------

// File: rtl/fpu_mul_round_dp.sv
// fpu_mul_round_dp
//   Back half of the binary64 multiplier. It takes the raw 106-bit mantissa
//   product, the biased exponent sum and the sign. It normalises the product,
//   rounds it (RNE or RTZ), detects overflow and underflow, and packs the
//   result and the exception flags.
//   The block is a two-stage pipeline with valid/ready on both sides and runs
//   at full throughput.
// Ports
//   clk, reset          clock, async active-high reset
//   in_valid/in_ready   upstream handshake
//   in_sign, in_exp     product sign, two's-complement eA+eB-1023
//   in_prod             {1,mA}*{1,mB}, 106 bits
//   in_class            0 normal, 1 zero, 2 inf, 3 NaN
//   in_invalid          upstream invalid-op, forwarded to flags[3]
//   rm                  0 RNE, 1 RTZ (sampled with in_valid)
//   out_valid/out_ready downstream handshake
//   result              packed binary64
//   flags               {invalid, overflow, underflow, inexact}
module fpu_mul_round_dp #(
  parameter int WIDTH = 64,
  parameter int EXP_W = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [105:0]     in_prod,
  input  logic [1:0]       in_class,
  input  logic             in_invalid,
  input  logic             rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam logic [1:0] CLS_NORM = 2'd0;
  localparam logic [1:0] CLS_ZERO = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;

  // Handshake: a stage may load when it is empty or its contents move on.
  logic s1_valid;
  logic s2_load, s1_load;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // ---------------- stage 1: normalise ----------------
  logic [51:0]      n_frac;
  logic             n_g, n_s;
  logic [EXP_W-1:0] n_exp;

  always_comb begin
    if (in_prod[105]) begin
      n_frac = in_prod[104:53];
      n_g    = in_prod[52];
      n_s    = |in_prod[51:0];
    end else begin
      n_frac = in_prod[103:52];
      n_g    = in_prod[51];
      n_s    = |in_prod[50:0];
    end
    n_exp = in_exp + {{(EXP_W-1){1'b0}}, in_prod[105]};
  end

  logic                    s1_sign, s1_g, s1_s, s1_inv, s1_rm;
  logic [51:0]             s1_frac;
  logic signed [EXP_W-1:0] s1_exp;
  logic [1:0]              s1_class;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_frac  <= '0;
      s1_g     <= 1'b0;
      s1_s     <= 1'b0;
      s1_exp   <= '0;
      s1_class <= '0;
      s1_inv   <= 1'b0;
      s1_rm    <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign  <= in_sign;
        s1_frac  <= n_frac;
        s1_g     <= n_g;
        s1_s     <= n_s;
        s1_exp   <= n_exp;
        s1_class <= in_class;
        s1_inv   <= in_invalid;
        s1_rm    <= rm;
      end
    end
  end

  // ---------------- stage 2: round / pack ----------------
  logic                  inc;
  logic [52:0]           sum;
  logic signed [EXP_W:0] e_r;   // one extra bit so the rounding carry cannot wrap
  logic [WIDTH-1:0]      p_res;
  logic [3:0]            p_flg;

  always_comb begin
    inc   = !s1_rm && s1_g && (s1_s || s1_frac[0]);
    sum   = {1'b0, s1_frac} + {52'd0, inc};
    // A carry out leaves sum[51:0] at zero, so the fraction needs no extra fixup.
    e_r   = {s1_exp[EXP_W-1], s1_exp} + {{EXP_W{1'b0}}, sum[52]};
    p_res = '0;
    p_flg = {s1_inv, 3'b000};
    case (s1_class)
      CLS_NORM: begin
        if (e_r >= 14'sd2047) begin
          p_flg[2] = 1'b1;
          p_flg[0] = 1'b1;
          p_res    = s1_rm ? {s1_sign, 11'h7FE, {52{1'b1}}} : {s1_sign, 11'h7FF, 52'd0};
        end else if (e_r <= 14'sd0) begin
          // No subnormal output: anything below the normal range flushes to zero.
          p_flg[1] = 1'b1;
          p_flg[0] = 1'b1;
          p_res    = {s1_sign, 63'd0};
        end else begin
          p_flg[0] = s1_g || s1_s;
          p_res    = {s1_sign, e_r[10:0], sum[51:0]};
        end
      end
      CLS_ZERO: p_res = {s1_sign, 63'd0};
      CLS_INF:  p_res = {s1_sign, 11'h7FF, 52'd0};
      default:  p_res = 64'h7FF8_0000_0000_0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= p_res;
        flags  <= p_flg;
      end
    end
  end

endmodule

// File: tb/tb_fpu_mul_round_dp.sv
module tb_fpu_mul_round_dp;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_sign, in_invalid, rm;
  logic [12:0]  in_exp;
  logic [105:0] in_prod;
  logic [1:0]   in_class;
  logic         out_valid, out_ready;
  logic [63:0]  result;
  logic [3:0]   flags;

  int n_chk = 0;
  int n_err = 0;
  logic [67:0] exp_q[$];   // {result, flags} in issue order

  always #5 clk = ~clk;

  fpu_mul_round_dp dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_prod(in_prod),
    .in_class(in_class), .in_invalid(in_invalid), .rm(rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every output transfer is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
      else begin
        logic [67:0] e;
        e = exp_q.pop_front();
        chk("result", result, e[67:4]);
        chk("flags", {60'd0, flags}, {60'd0, e[3:0]});
      end
    end
  end

  task automatic send(input logic s, input logic [12:0] e, input logic [105:0] p,
                      input logic [1:0] c, input logic inv, input logic r,
                      input logic [63:0] eres, input logic [3:0] eflg);
    bit ok;
    in_valid = 1'b1; in_sign = s; in_exp = e; in_prod = p;
    in_class = c; in_invalid = inv; rm = r;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("in_ready_timeout", 64'd0, 64'd1);
    else begin
      exp_q.push_back({eres, eflg});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    #1 chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  localparam logic [105:0] ONE = 106'd1;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_prod = '0;
    in_class = '0; in_invalid = 1'b0; rm = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", {60'd0, flags}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1.5*1.5 = 2.25, also checks the two-cycle latency
    send(0, 13'd1023, 106'd9 << 102, 0, 0, 0, 64'h4002_0000_0000_0000, 4'b0000);
    chk("lat_c1", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk("lat_c2", {63'd0, out_valid}, 64'd1);
    drain();

    // rounding cases
    send(0, 13'd1023, (ONE << 104) | (ONE << 52) | (ONE << 51), 0, 0, 0, 64'h3FF0_0000_0000_0002, 4'b0001);
    send(0, 13'd1023, (ONE << 104) | (ONE << 51), 0, 0, 0, 64'h3FF0_0000_0000_0000, 4'b0001);
    send(0, 13'd1023, (ONE << 104) | (ONE << 52) | (ONE << 51), 0, 0, 1, 64'h3FF0_0000_0000_0001, 4'b0001);
    send(0, 13'd1023, (ONE << 105) - (ONE << 51), 0, 0, 0, 64'h4000_0000_0000_0000, 4'b0001);
    // overflow and the largest in-range exponent
    send(0, 13'd2046, ONE << 105, 0, 0, 0, 64'h7FF0_0000_0000_0000, 4'b0101);
    send(0, 13'd2046, ONE << 105, 0, 0, 1, 64'h7FEF_FFFF_FFFF_FFFF, 4'b0101);
    send(0, 13'd2046, ONE << 104, 0, 0, 0, 64'h7FE0_0000_0000_0000, 4'b0000);
    // underflow and the smallest in-range exponent
    send(1, -13'sd5, ONE << 104, 0, 0, 0, 64'h8000_0000_0000_0000, 4'b0011);
    send(0, 13'd0, ONE << 104, 0, 0, 0, 64'h0000_0000_0000_0000, 4'b0011);
    send(0, 13'd0, ONE << 105, 0, 0, 0, 64'h0010_0000_0000_0000, 4'b0000);
    // specials
    send(1, -13'sd5, ONE << 104, 3, 0, 0, 64'h7FF8_0000_0000_0000, 4'b0000);
    send(0, 13'd0, '0, 3, 1, 0, 64'h7FF8_0000_0000_0000, 4'b1000);
    send(1, 13'd1023, ONE << 104, 1, 0, 0, 64'h8000_0000_0000_0000, 4'b0000);
    send(0, 13'd2046, ONE << 105, 2, 0, 1, 64'h7FF0_0000_0000_0000, 4'b0000);
    drain();

    // backpressure: two entries are held, the third waits for in_ready
    out_ready = 1'b0;
    fork
      begin
        send(0, 13'd1023, 106'd9 << 102, 0, 0, 0, 64'h4002_0000_0000_0000, 4'b0000);
        send(0, 13'd1023, ONE << 104, 0, 0, 0, 64'h3FF0_0000_0000_0000, 4'b0000);
        send(1, 13'd1024, ONE << 104, 0, 0, 0, 64'hC000_0000_0000_0000, 4'b0000);
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_held", result, 64'h4002_0000_0000_0000);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // reset with both stages full drops everything in flight
    out_ready = 1'b0;
    send(0, 13'd1023, ONE << 104, 0, 0, 0, 64'h3FF0_0000_0000_0000, 4'b0000);
    send(0, 13'd1023, ONE << 104, 0, 0, 0, 64'h3FF0_0000_0000_0000, 4'b0000);
    chk("full_out_valid", {63'd0, out_valid}, 64'd1);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_result", result, 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("post_rst_valid", {63'd0, out_valid}, 64'd0);

    send(0, 13'd1023, 106'd9 << 102, 0, 0, 0, 64'h4002_0000_0000_0000, 4'b0000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
